rob: RTL and testbench

- Reorder buffer sitting directly downstream of the reservation station and load/store buffer.
- Allocates an entry per issued instruction and returns the allocated ROB id to the decoder. Captures results broadcast by the RS (ALU) and the LSB.
- Answers operand queries from the decoder and retires entries strictly in program order.
- On a mispredicted branch at commit it flushes itself and drives rob_clear / clear_pc to the RS, LSB, decoder and fetch.

---
 rtl/rob.sv | 175 +++++++++++++++++
 tb/tb_rob.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, captures ALU/LSB results,
// answers operand lookups and retires in order, flushing on a mispredicted branch.
module rob #(
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_kind,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_pred_taken,
    input  logic [31:0]               issue_recover_pc,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    output logic                      full,
    input  logic                      rs_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]               rs_value,
    input  logic                      lsb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
    output logic                      query_ready1,
    output logic [31:0]               query_value1,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
    output logic                      query_ready2,
    output logic [31:0]               query_value2,
    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic                      store_commit,
    output logic [ROB_SIZE_WIDTH-1:0] store_rob_id,
    output logic                      rob_clear,
    output logic [31:0]               clear_pc
);
    localparam int N = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] CNT_FULL = (ROB_SIZE_WIDTH+1)'(N);
    localparam logic [1:0] K_REG = 2'd0, K_ST = 2'd1, K_BR = 2'd2, K_NONE = 2'd3;

    logic [N-1:0]              busy_q, ready_q, pred_q;
    logic [1:0]                kind_q  [N];
    logic [4:0]                rd_q    [N];
    logic [31:0]               pc_q    [N];
    logic [31:0]               value_q [N];
    logic [ROB_SIZE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_SIZE_WIDTH:0]   count_q, count_d;

    logic                      commit_valid_q, store_commit_q, rob_clear_q;
    logic [4:0]                commit_rd_q;
    logic [31:0]               commit_value_q, clear_pc_q;
    logic [ROB_SIZE_WIDTH-1:0] commit_rob_id_q, store_rob_id_q;

    logic accept, do_issue, rs_hit, lsb_hit, head_ok, mispred, retire;

    assign full         = (count_q == CNT_FULL);
    assign issue_rob_id = tail_q;

    // Nothing is accepted during the flush pulse: downstream is still discarding.
    assign accept   = !rob_clear_q;
    assign do_issue = issue_valid && !full && accept;
    assign rs_hit   = rs_ready && busy_q[rs_rob_id] && accept;
    assign lsb_hit  = lsb_ready && busy_q[lsb_rob_id] && accept;
    assign head_ok  = busy_q[head_q] && ready_q[head_q];
    assign mispred  = head_ok && (kind_q[head_q] == K_BR) && (value_q[head_q][0] != pred_q[head_q]);
    assign retire   = head_ok && !mispred;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispred) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire)   head_d = head_q + ROB_SIZE_WIDTH'(1);
            if (do_issue) tail_d = tail_q + ROB_SIZE_WIDTH'(1);
            count_d = count_q + (ROB_SIZE_WIDTH+1)'(do_issue) - (ROB_SIZE_WIDTH+1)'(retire);
        end
    end

    // Lookup with same-cycle broadcast bypass; LSB beats RS as in writeback.
    function automatic logic [32:0] lookup(input logic [ROB_SIZE_WIDTH-1:0] id);
        if (lsb_ready && lsb_rob_id == id) return {1'b1, lsb_value};
        if (rs_ready && rs_rob_id == id)   return {1'b1, rs_value};
        return {ready_q[id], value_q[id]};
    endfunction

    always_comb begin
        {query_ready1, query_value1} = lookup(query_id1);
        {query_ready2, query_value2} = lookup(query_id2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            commit_valid_q  <= 1'b0;
            store_commit_q  <= 1'b0;
            rob_clear_q     <= 1'b0;
            clear_pc_q      <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_rob_id_q <= '0;
            store_rob_id_q  <= '0;
        end else if (!rdy) begin
            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            rob_clear_q    <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            rob_clear_q    <= mispred;
            if (mispred) begin
                busy_q     <= '0;
                ready_q    <= '0;
                clear_pc_q <= pc_q[head_q];
            end else begin
                if (rs_hit)  ready_q[rs_rob_id]  <= 1'b1;
                if (lsb_hit) ready_q[lsb_rob_id] <= 1'b1;
                if (do_issue) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= (issue_kind == K_NONE);
                end
                if (retire) begin
                    busy_q[head_q] <= 1'b0;
                    case (kind_q[head_q])
                        K_REG: begin
                            commit_valid_q  <= 1'b1;
                            commit_rd_q     <= rd_q[head_q];
                            commit_value_q  <= value_q[head_q];
                            commit_rob_id_q <= head_q;
                        end
                        K_ST: begin
                            store_commit_q <= 1'b1;
                            store_rob_id_q <= head_q;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Payload needs no reset: it is only observed while busy/ready qualify it.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (do_issue) begin
                kind_q[tail_q]  <= issue_kind;
                rd_q[tail_q]    <= issue_rd;
                pred_q[tail_q]  <= issue_pred_taken;
                pc_q[tail_q]    <= issue_recover_pc;
                value_q[tail_q] <= '0;
            end
            if (rs_hit)  value_q[rs_rob_id]  <= rs_value;
            if (lsb_hit) value_q[lsb_rob_id] <= lsb_value;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_rob_id = commit_rob_id_q;
    assign store_commit  = store_commit_q;
    assign store_rob_id  = store_rob_id_q;
    assign rob_clear     = rob_clear_q;
    assign clear_pc      = clear_pc_q;
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus random traffic against a queue-based model.
module tb_rob;
    logic        clk = 0, rst = 1, rdy = 1;
    logic        issue_valid = 0, issue_pred_taken = 0;
    logic [1:0]  issue_kind = 0;
    logic [4:0]  issue_rd = 0;
    logic [31:0] issue_recover_pc = 0;
    logic [2:0]  issue_rob_id;
    logic        full;
    logic        rs_ready = 0, lsb_ready = 0;
    logic [2:0]  rs_rob_id = 0, lsb_rob_id = 0;
    logic [31:0] rs_value = 0, lsb_value = 0;
    logic [2:0]  query_id1 = 0, query_id2 = 0;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        commit_valid, store_commit, rob_clear;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, clear_pc;
    logic [2:0]  commit_rob_id, store_rob_id;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rob #(.ROB_SIZE_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_recover_pc(issue_recover_pc),
        .issue_rob_id(issue_rob_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .query_id1(query_id1), .query_ready1(query_ready1), .query_value1(query_value1),
        .query_id2(query_id2), .query_ready2(query_ready2), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit), .store_rob_id(store_rob_id),
        .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    // Model: the in-flight window is a queue in program order; membership = busy.
    typedef struct {
        logic [2:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] value;
        logic        ready;
    } ent_t;

    ent_t        mq[$];
    logic [2:0]  m_tail = 0;
    logic        e_cv = 0, e_sc = 0, e_rc = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_val = 0, e_pc = 0;
    logic [2:0]  e_cid = 0, e_sid = 0;

    task automatic model_step();
        logic was_full, blocked;
        ent_t h, e;
        if (rst) begin
            mq.delete(); m_tail = 0;
            e_cv = 0; e_sc = 0; e_rc = 0; e_rd = 0; e_val = 0; e_pc = 0; e_cid = 0; e_sid = 0;
            return;
        end
        if (!rdy) begin
            e_cv = 0; e_sc = 0; e_rc = 0;
            return;
        end
        was_full = (mq.size() == 8);
        blocked  = e_rc;
        e_cv = 0; e_sc = 0; e_rc = 0;
        if (mq.size() > 0 && mq[0].ready) begin
            h = mq[0];
            if (h.kind == 2'd2 && h.value[0] != h.pred) begin
                mq.delete(); m_tail = 0; e_rc = 1; e_pc = h.pc;
                return;
            end
            void'(mq.pop_front());
            if (h.kind == 2'd0) begin e_cv = 1; e_rd = h.rd; e_val = h.value; e_cid = h.id; end
            else if (h.kind == 2'd1) begin e_sc = 1; e_sid = h.id; end
        end
        if (blocked) return;
        foreach (mq[i]) if (rs_ready && mq[i].id == rs_rob_id) begin mq[i].value = rs_value; mq[i].ready = 1; end
        foreach (mq[i]) if (lsb_ready && mq[i].id == lsb_rob_id) begin mq[i].value = lsb_value; mq[i].ready = 1; end
        if (issue_valid && !was_full) begin
            e.id = m_tail; e.kind = issue_kind; e.rd = issue_rd; e.pred = issue_pred_taken;
            e.pc = issue_recover_pc; e.value = 0; e.ready = (issue_kind == 2'd3);
            mq.push_back(e);
            m_tail = m_tail + 3'd1;
        end
    endtask

    task automatic q_exp(input logic [2:0] id, output logic chk, output logic r, output logic [31:0] v);
        chk = 0; r = 0; v = 0;
        if (lsb_ready && lsb_rob_id == id) begin chk = 1; r = 1; v = lsb_value; end
        else if (rs_ready && rs_rob_id == id) begin chk = 1; r = 1; v = rs_value; end
        else foreach (mq[i]) if (mq[i].id == id) begin chk = 1; r = mq[i].ready; v = mq[i].value; end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; rs_ready = 0; lsb_ready = 0; rdy = 1;
    endtask

    task automatic iss(input logic [1:0] k, input logic [4:0] rd, input logic p, input logic [31:0] pc);
        issue_valid = 1; issue_kind = k; issue_rd = rd; issue_pred_taken = p; issue_recover_pc = pc;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset(); tick();
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full act=%0d req=0", full); end
        total++; if (issue_rob_id !== 3'd0) begin bad++; $display("FAIL rst_tail act=%0d req=0", issue_rob_id); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rst_cv act=%0d req=0", commit_valid); end
        total++; if (store_commit !== 1'b0) begin bad++; $display("FAIL rst_sc act=%0d req=0", store_commit); end
        total++; if (rob_clear !== 1'b0) begin bad++; $display("FAIL rst_clear act=%0d req=0", rob_clear); end
        total++; if (clear_pc !== 32'd0) begin bad++; $display("FAIL rst_pc act=%0h req=0", clear_pc); end
        total++; if (commit_value !== 32'd0) begin bad++; $display("FAIL rst_cval act=%0h req=0", commit_value); end
    endtask

    task automatic test_basic();
        do_reset();
        iss(2'd0, 5'd5, 0, 0); tick(); idle();
        total++; if (issue_rob_id !== 3'd1) begin bad++; $display("FAIL basic_tail act=%0d req=1", issue_rob_id); end
        rs_ready = 1; rs_rob_id = 0; rs_value = 32'h1234; tick(); idle();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL basic_early act=%0d req=0", commit_valid); end
        tick();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL basic_cv act=%0d req=1", commit_valid); end
        total++; if (commit_rd !== 5'd5) begin bad++; $display("FAIL basic_rd act=%0d req=5", commit_rd); end
        total++; if (commit_value !== 32'h1234) begin bad++; $display("FAIL basic_val act=%0h req=1234", commit_value); end
        total++; if (commit_rob_id !== 3'd0) begin bad++; $display("FAIL basic_id act=%0d req=0", commit_rob_id); end
        tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse act=%0d req=0", commit_valid); end
    endtask

    task automatic test_in_order();
        logic [2:0] base, id;
        base = m_tail;
        for (int i = 0; i < 3; i++) begin iss(2'd0, 5'(i + 1), 0, 0); tick(); end
        idle();
        for (int i = 2; i >= 0; i--) begin
            rs_ready = 1; rs_rob_id = base + 3'(i); rs_value = 32'h100 + 32'(i); tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            id = base + 3'(i);
            total++; if (commit_valid !== 1'b1 || commit_rob_id !== id) begin bad++; $display("FAIL order_id%0d act=%0d/%0d req=1/%0d", i, commit_valid, commit_rob_id, id); end
            total++; if (commit_value !== 32'h100 + 32'(i) || commit_rd !== 5'(i + 1)) begin bad++; $display("FAIL order_val%0d act=%0h/%0d req=%0h/%0d", i, commit_value, commit_rd, 32'h100 + 32'(i), i + 1); end
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin iss(2'd0, 5'(i), 0, 0); tick(); end
        idle();
        total++; if (full !== 1'b1 || issue_rob_id !== 3'd0) begin bad++; $display("FAIL full_8 act=%0d/%0d req=1/0", full, issue_rob_id); end
        iss(2'd0, 5'd31, 0, 0); tick(); idle();
        total++; if (full !== 1'b1 || issue_rob_id !== 3'd0) begin bad++; $display("FAIL full_9th act=%0d/%0d req=1/0", full, issue_rob_id); end
        rs_ready = 1; rs_rob_id = 0; rs_value = 32'hAA; tick(); idle();
        iss(2'd0, 5'd7, 0, 0); tick();
        total++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'd0) begin bad++; $display("FAIL full_commit act=%0d/%0d req=1/0", commit_valid, commit_rob_id); end
        total++; if (issue_rob_id !== 3'd0 || full !== 1'b0) begin bad++; $display("FAIL full_reject act=%0d/%0d req=0/0", issue_rob_id, full); end
        tick(); idle();
        total++; if (issue_rob_id !== 3'd1 || full !== 1'b1) begin bad++; $display("FAIL full_wrap act=%0d/%0d req=1/1", issue_rob_id, full); end
    endtask

    task automatic test_kinds();
        do_reset();
        iss(2'd1, 0, 0, 0); tick();
        iss(2'd2, 0, 1, 32'h44); tick();
        iss(2'd3, 0, 0, 0); tick();
        iss(2'd0, 5'd9, 0, 0); tick(); idle();
        lsb_ready = 1; lsb_rob_id = 0; lsb_value = 1; rs_ready = 1; rs_rob_id = 1; rs_value = 1; tick(); idle();
        rs_ready = 1; rs_rob_id = 3; rs_value = 32'h55; tick(); idle();
        total++; if (store_commit !== 1'b1 || store_rob_id !== 3'd0 || commit_valid !== 1'b0) begin bad++; $display("FAIL kind_store act=%0d/%0d/%0d req=1/0/0", store_commit, store_rob_id, commit_valid); end
        tick();
        total++; if (store_commit !== 1'b0 || commit_valid !== 1'b0 || rob_clear !== 1'b0) begin bad++; $display("FAIL kind_branch act=%0d/%0d/%0d req=0/0/0", store_commit, commit_valid, rob_clear); end
        tick();
        total++; if (commit_valid !== 1'b0 || rob_clear !== 1'b0) begin bad++; $display("FAIL kind_nop act=%0d/%0d req=0/0", commit_valid, rob_clear); end
        tick();
        total++; if (commit_valid !== 1'b1 || commit_rd !== 5'd9 || commit_rob_id !== 3'd3 || commit_value !== 32'h55) begin bad++; $display("FAIL kind_reg act=%0d/%0d/%0d/%0h req=1/9/3/55", commit_valid, commit_rd, commit_rob_id, commit_value); end
    endtask

    task automatic test_mispredict();
        do_reset();
        iss(2'd2, 0, 1, 32'h80); tick();
        iss(2'd0, 5'd3, 0, 0); tick(); idle();
        rs_ready = 1; rs_rob_id = 0; rs_value = 0; tick(); idle();
        tick();
        total++; if (rob_clear !== 1'b1 || clear_pc !== 32'h80) begin bad++; $display("FAIL mp_clear act=%0d/%0h req=1/80", rob_clear, clear_pc); end
        total++; if (commit_valid !== 1'b0 || issue_rob_id !== 3'd0 || full !== 1'b0) begin bad++; $display("FAIL mp_state act=%0d/%0d/%0d req=0/0/0", commit_valid, issue_rob_id, full); end
        rs_ready = 1; rs_rob_id = 1; rs_value = 32'h77; iss(2'd0, 5'd4, 0, 0); tick(); idle();
        query_id1 = 1; #1;
        total++; if (rob_clear !== 1'b0 || issue_rob_id !== 3'd0) begin bad++; $display("FAIL mp_ignore act=%0d/%0d req=0/0", rob_clear, issue_rob_id); end
        total++; if (query_ready1 !== 1'b0) begin bad++; $display("FAIL mp_wb_ignored act=%0d req=0", query_ready1); end
        iss(2'd0, 5'd4, 0, 0); tick(); idle();
        total++; if (issue_rob_id !== 3'd1) begin bad++; $display("FAIL mp_reissue act=%0d req=1", issue_rob_id); end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin iss(2'd0, 5'(i), 0, 0); tick(); end
        idle(); query_id1 = 3; query_id2 = 0; #1;
        total++; if (query_ready1 !== 1'b0 || query_ready2 !== 1'b0) begin bad++; $display("FAIL q_notready act=%0d/%0d req=0/0", query_ready1, query_ready2); end
        rs_ready = 1; rs_rob_id = 3; rs_value = 7; #1;
        total++; if (query_ready1 !== 1'b1 || query_value1 !== 32'd7) begin bad++; $display("FAIL q_bypass_rs act=%0d/%0h req=1/7", query_ready1, query_value1); end
        lsb_ready = 1; lsb_rob_id = 3; lsb_value = 9; #1;
        total++; if (query_value1 !== 32'd9) begin bad++; $display("FAIL q_bypass_lsb act=%0h req=9", query_value1); end
        tick(); idle(); #1;
        total++; if (query_ready1 !== 1'b1 || query_value1 !== 32'd9) begin bad++; $display("FAIL q_lsb_wins act=%0d/%0h req=1/9", query_ready1, query_value1); end
    endtask

    task automatic test_rdy_rst();
        rs_ready = 1; rs_rob_id = 0; rs_value = 32'h11; tick(); idle();
        rdy = 0; tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rdy_hold act=%0d req=0", commit_valid); end
        iss(2'd0, 5'd1, 0, 0); rdy = 0; tick();
        total++; if (commit_valid !== 1'b0 || issue_rob_id !== 3'd4) begin bad++; $display("FAIL rdy_frozen act=%0d/%0d req=0/4", commit_valid, issue_rob_id); end
        idle(); tick();
        total++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'd0 || commit_value !== 32'h11) begin bad++; $display("FAIL rdy_resume act=%0d/%0d/%0h req=1/0/11", commit_valid, commit_rob_id, commit_value); end
        do_reset();
        iss(2'd2, 0, 0, 32'h40); tick(); idle();
        rs_ready = 1; rs_rob_id = 0; rs_value = 1; tick(); idle();
        rst = 1; tick(); rst = 0;
        total++; if (rob_clear !== 1'b0 || clear_pc !== 32'd0 || commit_valid !== 1'b0 || store_commit !== 1'b0) begin bad++; $display("FAIL rst_over_flush act=%0d/%0h/%0d/%0d req=0/0/0/0", rob_clear, clear_pc, commit_valid, store_commit); end
        total++; if (issue_rob_id !== 3'd0 || commit_rob_id !== 3'd0) begin bad++; $display("FAIL rst_over_ptr act=%0d/%0d req=0/0", issue_rob_id, commit_rob_id); end
    endtask

    task automatic pick_wb(output logic [2:0] id, output logic [31:0] v);
        int k;
        v = $urandom;
        id = 3'($urandom_range(0, 7));
        if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
            k = $urandom_range(0, mq.size() - 1);
            id = mq[k].id;
            if (mq[k].kind == 2'd2) v[0] = ($urandom_range(0, 5) == 0) ? ~mq[k].pred : mq[k].pred;
        end
    endtask

    task automatic test_random();
        logic c1, c2, r1, r2;
        logic [31:0] v1, v2;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_kind = 2'($urandom_range(0, 3)); issue_rd = 5'($urandom);
            issue_pred_taken = 1'($urandom); issue_recover_pc = $urandom;
            rs_ready = 1'($urandom); pick_wb(rs_rob_id, rs_value);
            lsb_ready = ($urandom_range(0, 2) == 0); pick_wb(lsb_rob_id, lsb_value);
            query_id1 = 3'($urandom); query_id2 = 3'($urandom);
            #1;
            q_exp(query_id1, c1, r1, v1);
            q_exp(query_id2, c2, r2, v2);
            total++; if (full !== (mq.size() == 8) || issue_rob_id !== m_tail) begin bad++; $display("FAIL rnd_alloc c=%0d act=%0d/%0d req=%0d/%0d", c, full, issue_rob_id, mq.size() == 8, m_tail); end
            if (c1) begin total++; if (query_ready1 !== r1 || (r1 && query_value1 !== v1)) begin bad++; $display("FAIL rnd_q1 c=%0d act=%0d/%0h req=%0d/%0h", c, query_ready1, query_value1, r1, v1); end end
            if (c2) begin total++; if (query_ready2 !== r2 || (r2 && query_value2 !== v2)) begin bad++; $display("FAIL rnd_q2 c=%0d act=%0d/%0h req=%0d/%0h", c, query_ready2, query_value2, r2, v2); end end
            tick();
            total++; if (commit_valid !== e_cv || commit_rd !== e_rd || commit_value !== e_val || commit_rob_id !== e_cid) begin bad++; $display("FAIL rnd_commit c=%0d act=%0d/%0d/%0h/%0d req=%0d/%0d/%0h/%0d", c, commit_valid, commit_rd, commit_value, commit_rob_id, e_cv, e_rd, e_val, e_cid); end
            total++; if (store_commit !== e_sc || store_rob_id !== e_sid) begin bad++; $display("FAIL rnd_store c=%0d act=%0d/%0d req=%0d/%0d", c, store_commit, store_rob_id, e_sc, e_sid); end
            total++; if (rob_clear !== e_rc || clear_pc !== e_pc) begin bad++; $display("FAIL rnd_clear c=%0d act=%0d/%0h req=%0d/%0h", c, rob_clear, clear_pc, e_rc, e_pc); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_in_order();
        test_full_wrap();
        test_kinds();
        test_mispredict();
        test_query();
        test_rdy_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
